// File: rtl/afifo_wr_arb_pkg.sv
// rtl/afifo_wr_arb_pkg.sv - shared types and limits for the afifo write-side arbiter
package afifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int unsigned NR_MIN = 2;
    localparam int unsigned NR_MAX = 16;
    localparam int unsigned CW_MIN = 1;
    localparam int unsigned CW_MAX = 32;

endpackage

// File: rtl/afifo_wr_arb_rr_pick.sv
// rtl/afifo_wr_arb_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module rr_pick #(
    parameter int unsigned NR = 4,
    parameter int unsigned IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic [NR-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [NR-1:0] win_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan NR positions starting at ptr_i, wrapping; the first request found wins.
    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < int'(NR); k++) begin
            j = int'(ptr_i) + k;
            if (j >= int'(NR)) begin
                j = j - int'(NR);
            end
            jj = j[IW-1:0];
            if (!any_o && req_i[jj]) begin
                any_o     = 1'b1;
                idx_o     = jj;
                win_o[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// rtl/afifo_wr_arb.sv - round-robin burst arbiter sharing one afifo write port
module afifo_wr_arb
    import afifo_wr_arb_pkg::*;
#(
    parameter int unsigned NR = 4,
    parameter int unsigned DW = 128,
    parameter int unsigned CW = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NR-1:0]    req_valid,
    input  logic [NR-1:0]    req_last,
    input  logic [NR*DW-1:0] req_data,
    output logic [NR-1:0]    req_ready,
    output logic             fifo_we,
    output logic [DW-1:0]    fifo_d,
    input  logic             fifo_wfull,
    input  logic             fifo_wafull,
    output logic [NR-1:0]    grant,
    output logic             busy,
    output logic [CW-1:0]    burst_beats
);

    localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;

    arb_state_e    state_q, state_d;
    logic [NR-1:0] grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] burst_beats_q, burst_beats_d;

    logic [NR-1:0] pick_win;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          accept;
    logic          last_beat;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    rr_pick #(
        .NR (NR),
        .IW (IW)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Owner's beat path to the FIFO; only fifo_wfull stalls a burst in flight.
    always_comb begin
        req_ready = '0;
        fifo_we   = 1'b0;
        fifo_d    = '0;
        accept    = 1'b0;
        last_beat = 1'b0;
        if (state_q == XFER) begin
            req_ready = grant_q & {NR{~fifo_wfull}};
            accept    = req_valid[owner_q] & ~fifo_wfull;
            fifo_we   = accept;
            fifo_d    = req_data[32'(owner_q)*DW +: DW];
            last_beat = accept & req_last[owner_q];
        end
    end

    // Burst-level FSM: almost-full only gates the start of a new burst.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        burst_beats_d = burst_beats_q;
        case (state_q)
            IDLE: begin
                if (pick_any && !fifo_wafull) begin
                    state_d = XFER;
                    grant_d = pick_win;
                    owner_d = pick_idx;
                end
            end
            XFER: begin
                if (accept) begin
                    if (last_beat) begin
                        burst_beats_d = sat_inc(beat_cnt_q);
                        beat_cnt_d    = '0;
                        rr_ptr_d      = (owner_q == IW'(NR - 1)) ? '0 : owner_q + 1'b1;
                        grant_d       = '0;
                        state_d       = IDLE;
                    end else begin
                        beat_cnt_d = sat_inc(beat_cnt_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            burst_beats_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            burst_beats_q <= burst_beats_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == XFER);
    assign burst_beats = burst_beats_q;

endmodule
